// File: rtl/cache_traffic_gen_pkg.sv
// Shared types and helpers for the cache traffic generator: request opcodes, bus widths,
// FSM state encoding and the expected-data pattern.
package cache_traffic_gen_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_REQ  = 2'd2,
        ST_DONE = 2'd3
    } ctg_state_e;

    // The pass number is folded into bits [23:16] so data left over from the previous pass fails.
    function automatic logic [DATA_W-1:0] ctg_exp(input logic [DATA_W-1:0] tag,
                                                  input logic [ADDR_W-1:0] addr,
                                                  input logic [7:0]        pass);
        return (tag | addr) ^ {40'b0, pass, 16'b0};
    endfunction

endpackage

// File: rtl/cache_traffic_gen_if.sv
// Request port between the traffic generator (master) and cache_core (slave).
interface cache_traffic_gen_if;
    import cache_traffic_gen_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        bytes;
    logic              op;
    logic              req;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output addr, wdata, bytes, op, req, input rdata, ack);
    modport slave  (input addr, wdata, bytes, op, req, output rdata, ack);

endinterface

// File: rtl/cache_traffic_gen_checker.sv
// Read-data checker: compares returned data against the expected pattern, keeps a saturating
// error count and the address of the first mismatch since the last clear.
module ctg_checker
    import cache_traffic_gen_pkg::*;
#(
    parameter logic [DATA_W-1:0] TAG   = 64'h0123_4567_0000_0000,
    parameter int                CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_chk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_pass,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [CNT_W-1:0]  o_err_cnt,
    output logic [ADDR_W-1:0] o_err_addr
);

    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        mismatch   = i_chk && (i_rdata != ctg_exp(TAG, i_addr, i_pass));
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        if (i_clear) begin
            err_cnt_d  = '0;
            err_addr_d = '0;
        end else if (mismatch) begin
            if (err_cnt_q == '0) err_addr_d = i_addr;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    assign o_err_cnt  = err_cnt_q;
    assign o_err_addr = err_addr_q;

endmodule

// File: rtl/cache_traffic_gen.sv
// Self-checking cache request generator: walks an address window writing a tagged pattern,
// reads it back in interleaved or block order and reports mismatches per run.
//   state | meaning
//   IDLE  | waiting for i_start after reset
//   GAP   | idle spacing before the next request
//   REQ   | request outstanding, waiting for ack
//   DONE  | run complete, results held until next i_start
module cache_traffic_gen
    import cache_traffic_gen_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_BASE = 64'h8000_0000,
    parameter logic [ADDR_W-1:0] ADDR_LAST = 64'h8000_11F8,
    parameter logic [ADDR_W-1:0] STRIDE    = 64'h8,
    parameter logic [2:0]        BYTES     = 3'd7,
    parameter int                GAP       = 5,
    parameter int                PASSES    = 2,
    parameter logic [DATA_W-1:0] TAG       = 64'h0123_4567_0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic                       i_mode,
    cache_traffic_gen_if.master        cache_core,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [15:0]                o_err_cnt,
    output logic [ADDR_W-1:0]          o_err_addr,
    output logic [15:0]                o_pass_cnt
);

    localparam int CNT_W = $clog2(GAP + 2);

    ctg_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, next_addr;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              op_q, op_d, req_q, req_d, mode_q, mode_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [15:0]       pass_q, pass_d, pass_inc;
    logic              hs, start_ok, rd_chk, at_last;

    assign hs = req_q & cache_core.ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= ADDR_BASE;
            wdata_q <= '0;
            op_q    <= REQ_READ;
            req_q   <= 1'b0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            req_q   <= req_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        op_d      = op_q;
        req_d     = req_q;
        mode_d    = mode_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        start_ok  = 1'b0;
        rd_chk    = 1'b0;
        pass_inc  = pass_q + 16'd1;
        at_last   = (addr_q == ADDR_LAST);
        // Wrap is an explicit equality test so a window near the top of memory never overflows.
        next_addr = at_last ? ADDR_BASE : addr_q + STRIDE;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    start_ok = 1'b1;
                    state_d  = ST_GAP;
                    cnt_d    = '0;
                    addr_d   = ADDR_BASE;
                    op_d     = REQ_WRITE;
                    mode_d   = i_mode;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = '0;
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP)) begin
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REQ: begin
                if (hs) begin
                    req_d   = 1'b0;
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    if (op_q == REQ_WRITE) begin
                        if (mode_q) begin
                            addr_d = next_addr;
                            if (at_last) op_d = REQ_READ;
                        end else begin
                            op_d = REQ_READ;
                        end
                    end else begin
                        rd_chk = 1'b1;
                        addr_d = next_addr;
                        op_d   = (mode_q && !at_last) ? REQ_READ : REQ_WRITE;
                        if (at_last) begin
                            pass_d = pass_inc;
                            if (PASSES != 0 && pass_inc == 16'(PASSES)) begin
                                state_d = ST_DONE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
            end
            default: ;
        endcase

        // addr/pass only move on start or handshake, so refresh the pattern exactly then.
        wdata_d = (start_ok || hs) ? ctg_exp(TAG, addr_d, pass_d[7:0]) : wdata_q;
    end

    always_comb begin
        cache_core.req   = req_q;
        cache_core.addr  = addr_q;
        cache_core.op    = op_q;
        cache_core.wdata = wdata_q;
        cache_core.bytes = BYTES;
        o_busy           = busy_q;
        o_done           = done_q;
        o_pass_cnt       = pass_q;
    end

    ctg_checker #(
        .TAG   (TAG),
        .CNT_W (16)
    ) u_checker (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (start_ok),
        .i_chk      (rd_chk),
        .i_addr     (addr_q),
        .i_pass     (pass_q[7:0]),
        .i_rdata    (cache_core.rdata),
        .o_err_cnt  (o_err_cnt),
        .o_err_addr (o_err_addr)
    );

endmodule

// File: tb/tb_cache_traffic_gen.sv
// Bench for cache_traffic_gen: memory responder with random latency and read corruption,
// a pass-level reference sequence, a narrow checker for saturation, and GAP=0 throughput.
module tb_cache_traffic_gen;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] TAG  = 64'h0123_4567_0000_0000;

    typedef struct packed {
        logic        op;
        logic [63:0] addr;
        logic [63:0] wdata;
    } hs_t;

    typedef struct {
        bit          mode;
        int          lat_lo;
        int          lat_hi;
        logic [7:0]  mask;
        logic [15:0] exp_err;
        logic [63:0] exp_eaddr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- DUT A: window of four addresses, two passes, GAP=5
    cache_traffic_gen_if a_if ();
    logic        a_start, a_mode, a_busy, a_done;
    logic [15:0] a_err_cnt, a_pass;
    logic [63:0] a_err_addr;

    cache_traffic_gen #(.ADDR_LAST(64'h8000_0018), .PASSES(2)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .i_start    (a_start),
        .i_mode     (a_mode),
        .cache_core (a_if),
        .o_busy     (a_busy),
        .o_done     (a_done),
        .o_err_cnt  (a_err_cnt),
        .o_err_addr (a_err_addr),
        .o_pass_cnt (a_pass)
    );

    // ---------------- DUT B: GAP=0, runs until reset, ack tied to req
    cache_traffic_gen_if b_if ();
    logic        b_start, b_mode, b_busy, b_done;
    logic [15:0] b_err_cnt, b_pass;
    logic [63:0] b_err_addr;
    logic [63:0] b_mem [4];
    logic [63:0] b_off;

    cache_traffic_gen #(.ADDR_LAST(64'h8000_0018), .GAP(0), .PASSES(0)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .i_start    (b_start),
        .i_mode     (b_mode),
        .cache_core (b_if),
        .o_busy     (b_busy),
        .o_done     (b_done),
        .o_err_cnt  (b_err_cnt),
        .o_err_addr (b_err_addr),
        .o_pass_cnt (b_pass)
    );

    assign b_off      = b_if.addr - BASE;
    assign b_if.ack   = b_if.req;
    assign b_if.rdata = b_mem[b_off[4:3]];
    always @(posedge clk) if (b_if.req && b_if.ack && b_if.op) b_mem[b_off[4:3]] <= b_if.wdata;

    // ---------------- Narrow checker to reach saturation quickly
    logic        c_clear, c_chk;
    logic [63:0] c_addr, c_rdata;
    logic [7:0]  c_pass;
    logic [3:0]  c_err_cnt;
    logic [63:0] c_err_addr;

    ctg_checker #(.TAG(TAG), .CNT_W(4)) u_chk (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (c_clear),
        .i_chk      (c_chk),
        .i_addr     (c_addr),
        .i_pass     (c_pass),
        .i_rdata    (c_rdata),
        .o_err_cnt  (c_err_cnt),
        .o_err_addr (c_err_addr)
    );

    // ---------------- Memory responder for DUT A
    bit          resp_en;
    logic        man_ack;
    int          lat_lo, lat_hi, cur_lat, wait_cnt, reads_seen;
    logic [7:0]  corrupt_mask;
    logic [63:0] mem_a [4];
    logic [63:0] cap_addr, cap_wdata;
    logic        cap_op;
    hs_t         trace [$];
    hs_t         exp_q [$];

    function automatic logic [63:0] mdl_exp(input logic [63:0] addr, input int p);
        return (TAG | addr) ^ (64'(p % 256) << 16);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int idx;
        if (!resp_en) begin
            a_if.ack = man_ack;
        end else if (!a_if.req) begin
            a_if.ack = 1'b0;
            wait_cnt = 0;
        end else if (!a_if.ack) begin
            if (wait_cnt == 0) begin
                cur_lat   = int'($urandom_range(lat_hi, lat_lo));
                cap_addr  = a_if.addr;
                cap_wdata = a_if.wdata;
                cap_op    = a_if.op;
            end
            wait_cnt++;
            if (wait_cnt >= cur_lat) begin
                if (cur_lat > 1) begin
                    chk("stable_addr", a_if.addr, cap_addr);
                    chk("stable_wdata", a_if.wdata, cap_wdata);
                    chk("stable_op", a_if.op, cap_op);
                end
                a_if.ack = 1'b1;
                trace.push_back('{op: a_if.op, addr: a_if.addr, wdata: a_if.wdata});
                idx = int'((a_if.addr - BASE) >> 3);
                if (idx >= 0 && idx < 4) begin
                    if (a_if.op) begin
                        mem_a[idx] = a_if.wdata;
                    end else begin
                        a_if.rdata = mem_a[idx];
                        if (corrupt_mask[reads_seen % 8]) a_if.rdata = a_if.rdata ^ 64'h1;
                    end
                end
                if (!a_if.op) reads_seen++;
            end
        end
    end

    // Reference: two passes over four addresses, in W/R pairs or in W-block then R-block order.
    task automatic build_exp(input bit mode);
        exp_q.delete();
        for (int p = 0; p < 2; p++) begin
            if (!mode) begin
                for (int i = 0; i < 4; i++) begin
                    exp_q.push_back('{op: 1'b1, addr: BASE + 64'(8 * i), wdata: mdl_exp(BASE + 64'(8 * i), p)});
                    exp_q.push_back('{op: 1'b0, addr: BASE + 64'(8 * i), wdata: mdl_exp(BASE + 64'(8 * i), p)});
                end
            end else begin
                for (int i = 0; i < 4; i++)
                    exp_q.push_back('{op: 1'b1, addr: BASE + 64'(8 * i), wdata: mdl_exp(BASE + 64'(8 * i), p)});
                for (int i = 0; i < 4; i++)
                    exp_q.push_back('{op: 1'b0, addr: BASE + 64'(8 * i), wdata: mdl_exp(BASE + 64'(8 * i), p)});
            end
        end
    endtask

    task automatic run_a(input bit mode, input int lo, input int hi, input logic [7:0] mask,
                         input logic [15:0] exp_err, input logic [63:0] exp_eaddr);
        int n;
        build_exp(mode);
        trace.delete();
        reads_seen   = 0;
        lat_lo       = lo;
        lat_hi       = hi;
        corrupt_mask = mask;
        @(negedge clk);
        a_mode  = mode;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("busy_after_start", a_busy, 1);
        chk("done_cleared", a_done, 0);
        n = 0;
        while (a_done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("run_finished", a_done, 1);
        chk("busy_at_end", a_busy, 0);
        chk("req_at_end", a_if.req, 0);
        chk("pass_cnt", a_pass, 2);
        chk("err_cnt", a_err_cnt, exp_err);
        chk("err_addr", a_err_addr, exp_eaddr);
        chk("trace_len", trace.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < trace.size(); i++) begin
            chk($sformatf("hs%0d_op", i), trace[i].op, exp_q[i].op);
            chk($sformatf("hs%0d_addr", i), trace[i].addr, exp_q[i].addr);
            chk($sformatf("hs%0d_wdata", i), trace[i].wdata, exp_q[i].wdata);
        end
    endtask

    task automatic test_checker();
        logic [63:0] ea;
        int          m_cnt;
        logic [63:0] m_addr;
        bit          match;
        @(negedge clk);
        c_clear = 1'b1;
        @(negedge clk);
        c_clear = 1'b0;
        chk("chk_clear_cnt", c_err_cnt, 0);
        m_cnt  = 0;
        m_addr = '0;
        for (int k = 0; k < 30; k++) begin
            c_addr  = BASE + 64'(k * 8);
            c_pass  = 8'(k);
            c_chk   = (k % 5 != 4);
            match   = (k == 0 || k == 3);
            ea      = mdl_exp(c_addr, k);
            c_rdata = match ? ea : ea ^ 64'h10;
            if (c_chk && !match) begin
                if (m_cnt == 0) m_addr = c_addr;
                if (m_cnt < 15) m_cnt++;
            end
            @(posedge clk);
            #1;
            chk($sformatf("chk%0d_cnt", k), c_err_cnt, 64'(m_cnt));
            chk($sformatf("chk%0d_addr", k), c_err_addr, m_addr);
            @(negedge clk);
        end
        c_chk   = 1'b1;
        c_rdata = 64'h0;
        c_clear = 1'b1;
        @(posedge clk);
        #1;
        chk("chk_clear_wins_cnt", c_err_cnt, 0);
        chk("chk_clear_wins_addr", c_err_addr, 0);
        @(negedge clk);
        c_clear = 1'b0;
        c_chk   = 1'b0;
    endtask

    vec_t vecs [4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, hs_seen, alt_err, pc_err, b;
        bit          prev;
        bit          r_mode;
        int          r_hi;
        logic [7:0]  r_mask;
        logic [63:0] r_eaddr;

        vecs[0] = '{mode: 1'b0, lat_lo: 1, lat_hi: 1,  mask: 8'h00, exp_err: 16'd0, exp_eaddr: 64'h0};
        vecs[1] = '{mode: 1'b1, lat_lo: 1, lat_hi: 20, mask: 8'h00, exp_err: 16'd0, exp_eaddr: 64'h0};
        vecs[2] = '{mode: 1'b0, lat_lo: 1, lat_hi: 1,  mask: 8'h14, exp_err: 16'd2, exp_eaddr: 64'h8000_0010};
        vecs[3] = '{mode: 1'b1, lat_lo: 1, lat_hi: 20, mask: 8'h14, exp_err: 16'd2, exp_eaddr: 64'h8000_0010};

        rst = 1'b1;
        a_start = 1'b0; a_mode = 1'b0; b_start = 1'b0; b_mode = 1'b0;
        resp_en = 1'b1; man_ack = 1'b0;
        lat_lo = 1; lat_hi = 1; corrupt_mask = '0; reads_seen = 0; wait_cnt = 0; cur_lat = 1;
        c_clear = 1'b0; c_chk = 1'b0; c_addr = '0; c_pass = '0; c_rdata = '0;
        repeat (3) @(negedge clk);

        chk("rst_req", a_if.req, 0);
        chk("rst_op", a_if.op, 0);
        chk("rst_addr", a_if.addr, BASE);
        chk("rst_wdata", a_if.wdata, 0);
        chk("rst_bytes", a_if.bytes, 7);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_err_cnt", a_err_cnt, 0);
        chk("rst_err_addr", a_err_addr, 0);
        chk("rst_pass", a_pass, 0);
        rst = 1'b0;

        test_checker();

        for (int v = 0; v < 4; v++) begin
            run_a(vecs[v].mode, vecs[v].lat_lo, vecs[v].lat_hi, vecs[v].mask, vecs[v].exp_err, vecs[v].exp_eaddr);
            if (v == 0) begin
                chk("pass2_trace_present", trace.size() > 10, 1);
                if (trace.size() > 10) chk("pass2_wdata_08", trace[10].wdata, 64'h0123_4567_8001_0008);
            end
        end

        for (int r = 0; r < 4; r++) begin
            r_mode  = 1'($urandom_range(1, 0));
            r_hi    = int'($urandom_range(8, 1));
            r_mask  = 8'($urandom_range(255, 0));
            r_eaddr = '0;
            for (b = 7; b >= 0; b--) if (r_mask[b]) r_eaddr = BASE + 64'(8 * (b % 4));
            run_a(r_mode, 1, r_hi, r_mask, 16'($countones(r_mask)), r_eaddr);
        end

        // Reset while a request is pending and the ack is about to arrive.
        resp_en = 1'b0;
        man_ack = 1'b0;
        @(negedge clk);
        a_mode  = 1'b0;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        n = 0;
        while (a_if.req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_req_seen", a_if.req, 1);
        rst     = 1'b1;
        man_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_req", a_if.req, 0);
        chk("midrst_busy", a_busy, 0);
        chk("midrst_addr", a_if.addr, BASE);
        chk("midrst_done", a_done, 0);
        repeat (3) @(negedge clk);
        chk("late_ack_req", a_if.req, 0);
        chk("late_ack_busy", a_busy, 0);
        chk("late_ack_pass", a_pass, 0);
        chk("late_ack_err", a_err_cnt, 0);
        man_ack = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);
        run_a(1'b0, 1, 3, 8'h00, 16'd0, 64'h0);

        // GAP=0 with ack tied to req: alternating req, and a mid-run start is ignored.
        @(negedge clk);
        b_mode  = 1'b0;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        n = 0;
        while (b_if.req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("b_first_req", b_if.req, 1);
        hs_seen = 0; alt_err = 0; pc_err = 0; prev = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (b_pass !== 16'(hs_seen / 8)) pc_err++;
            if (c > 0 && b_if.req === prev) alt_err++;
            prev = b_if.req;
            if (b_if.req && b_if.ack) hs_seen++;
            b_start = (c == 30);
            @(negedge clk);
        end
        b_start = 1'b0;
        chk("b_alternation_errors", alt_err, 0);
        chk("b_hs_count", hs_seen, 32);
        chk("b_pass_track_errors", pc_err, 0);
        chk("b_pass_cnt", b_pass, 4);
        chk("b_busy", b_busy, 1);
        chk("b_err_cnt", b_err_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_traffic_gen.md
Name: cache_traffic_gen

Overview:
- Parametrised, self-checking request generator that drives the cache_core request port (req/ack, op, addr, wdata, bytes).
- Walks a configurable address window with a configurable stride. Writes a tagged pattern, reads it back and compares.
- Supports two ordering modes and multiple passes; reports error count, first failing address and completion status.
- Instantiated beside cache_core in bring-up and regression tops, replacing hand-written request sequencers.

Parameters:
ADDR_BASE, 64'h8000_0000, first byte address of the window
ADDR_LAST, 64'h8000_11F8, last address accessed (inclusive); must equal ADDR_BASE + k*STRIDE
STRIDE, 64'h8, address increment per access
BYTES, 3'd7, value driven on o_cache_core_bytes (7 = 8 bytes)
GAP, 5, idle cycles between a handshake and the next req assertion (0 allowed)
PASSES, 2, number of full passes per run; 0 = run until reset
TAG, 64'h01234567_0000_0000, data tag OR-ed with the address

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
i_start  in  1  one-cycle pulse; starts a run when idle
i_mode  in  1  0 = interleaved (W then R per address); 1 = block (write whole window, then read whole window); sampled at start
o_cache_core_addr  out  64  request address
o_cache_core_wdata  out  64  write data
o_cache_core_bytes  out  3  byte count
o_cache_core_op  out  1  0 = REQ_READ, 1 = REQ_WRITE
o_cache_core_req  out  1  request valid
i_cache_core_rdata  in  64  read data
i_cache_core_ack  in  1  handshake acknowledge
o_busy  out  1  run in progress
o_done  out  1  run finished; held until next start
o_err_cnt  out  16  mismatching reads, saturating at 16'hFFFF
o_err_addr  out  64  address of first mismatch in the run
o_pass_cnt  out  16  completed passes

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: req=0, op=READ, addr=ADDR_BASE, wdata=0, bytes=BYTES, busy=0, done=0, err_cnt=0, err_addr=0, pass_cnt=0.
- Reset mid-run takes effect on that edge: req drops, all state returns to IDLE. Any outstanding ack after reset is ignored.
- Handshake: hs = req & ack.
  - req, addr, op and wdata are held stable from req assertion until hs.
  - req deasserts on the edge after hs.
  - ack while req=0 is ignored.
- Expected data: exp(addr, pass) = (TAG | addr) ^ {40'b0, pass[7:0], 16'b0}. The pass term makes stale data from the previous pass fail.
- FSM states: IDLE, GAP, REQ, DONE.
  - IDLE: on i_start, clear err_cnt, err_addr and pass_cnt. Load addr=ADDR_BASE and op=WRITE. Latch mode, set busy=1, clear done, go to GAP with the counter at 0.
  - GAP: count up each cycle. When count >= GAP, assert req and go to REQ. With GAP=0, req rises the cycle after entry.
  - REQ: wait for hs, then step (see below) and return to GAP with the counter cleared.
  - DONE: busy=0, done=1; on i_start behave as IDLE.
  - i_start in GAP, REQ or DONE-exit transitions is ignored while busy.
- Step, interleaved mode:
  - After a write hs: op=READ, addr unchanged.
  - After a read hs: compare, op=WRITE, advance addr.
- Step, block mode:
  - Writes advance addr. At ADDR_LAST the address wraps to ADDR_BASE and op switches to READ.
  - Reads compare and advance. At ADDR_LAST the pass ends.
- Address advance: addr + STRIDE. After ADDR_LAST the address wraps to ADDR_BASE; wrap is detected with equality, never by overflow.
- End of pass: a read hs at ADDR_LAST.
  - pass_cnt increments and op=WRITE.
  - If PASSES != 0 and pass_cnt+1 == PASSES, go to DONE; otherwise continue with the next pass.
- Compare: on read hs, mismatch = rdata != exp(addr, pass_cnt).
  - On mismatch, err_cnt increments (saturating).
  - err_addr captures addr only when err_cnt==0 before the increment.
- wdata is updated combinationally-equivalent to exp(addr, pass_cnt) whenever addr or pass_cnt changes. It is registered and valid at req assertion.

Decomposition:
- Shared defines header holds REQ_READ/REQ_WRITE, the bus-width macros and the 2-bit FSM state encodings.
- One natural sub-module, ctg_checker: holds the exp() function, the mismatch compare, the saturating err_cnt and first-error capture.
- The FSM and address walker remain in the top.

Test Plan:
- Zero-latency memory model (ack 1 cycle after req), mode 0, PASSES=2, window 0x8000_0000..0x8000_0018:
  - 16 hs in order W0,R0,W8,R8,...
  - done=1, err_cnt=0, pass_cnt=2.
  - Second-pass wdata at 0x8000_0008 = 0x01234567_8001_0008.
- Mode 1, same window, random ack latency 1..20:
  - four writes precede four reads each pass.
  - req/addr/wdata stable while waiting for ack.
  - err_cnt=0.
- Model corrupts the read at 0x8000_0010 in pass 1 and at 0x8000_0000 in pass 2: err_cnt=2, err_addr=0x8000_0010.
- Model returns rdata=0 always, window of 70000 reads, PASSES=1: err_cnt saturates at 0xFFFF; err_addr=0x8000_0000.
- rst asserted while req=1 and ack pending: next cycle req=0, busy=0, addr=0x8000_0000. A late ack is ignored. A subsequent i_start reruns cleanly.
- GAP=0 with ack tied to req: one hs every 2 cycles. i_start pulsed mid-run has no effect.
